hilo_ctrl: RTL and testbench

Execute-stage front end for the multiply/divide unit `mult`. Decodes the MD-class instruction in E, issues one-cycle `start` pulses with operands and op code to `mult`, and tracks its `Busy` to know when results are ready. Holds the architectural HI/LO registers and serves mthi/mtlo/mfhi/mflo. Generates the E-stage stall for any MD instruction that arrives while a multiply or divide is outstanding.

---
 rtl/hilo_ctrl.sv | 71 +++++++
 tb/tb_hilo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: E-stage front end for the multiply/divide unit, owning HI/LO and MD stalls
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        mul_start,
    output logic [2:0]  mul_op,
    output logic [31:0] mul_A,
    output logic [31:0] mul_B,
    input  logic        mul_busy,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo
);
    typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;
    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    // Decode in IDLE, skip the Busy-rise gap in ARM, harvest the result in WAIT; reset forces all outputs low
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall     = 1'b0;
        mul_start = 1'b0;
        mul_op    = 3'd0;
        mul_A     = 32'd0;
        mul_B     = 32'd0;
        rd_data   = 32'd0;
        if (reset) begin
            stall = md_valid && state_q != IDLE;
            case (state_q)
                IDLE: if (md_valid) begin
                    if (!md_op[2]) begin
                        mul_start = 1'b1;
                        mul_op    = md_op + 3'd1;
                        mul_A     = rs_val;
                        mul_B     = rt_val;
                        state_d   = ARM;
                    end else begin
                        rd_data = md_op[1:0] == 2'd0 ? hi_q : md_op[1:0] == 2'd1 ? lo_q : 32'd0;
                        hi_d    = md_op[1:0] == 2'd2 ? rs_val : hi_q;
                        lo_d    = md_op[1:0] == 2'd3 ? rs_val : lo_q;
                    end
                end
                ARM: state_d = WAIT;
                WAIT: if (!mul_busy) begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State and HI/LO registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: randomized and directed checks of hilo_ctrl against a behavioural model and a mult stand-in
module tb_hilo_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_valid = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        stall;
    logic [31:0] rd_data;
    logic        mul_start;
    logic [2:0]  mul_op;
    logic [31:0] mul_A;
    logic [31:0] mul_B;
    logic        mul_busy = 1'b0;
    logic [31:0] mul_hi = 32'd0;
    logic [31:0] mul_lo = 32'd0;

    int checks = 0;
    int failures = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    hilo_ctrl dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_data(rd_data),
        .mul_start(mul_start), .mul_op(mul_op), .mul_A(mul_A), .mul_B(mul_B),
        .mul_busy(mul_busy), .mul_hi(mul_hi), .mul_lo(mul_lo)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic of mult: {HI, LO}; division gives remainder in HI and quotient in LO
    function automatic logic [63:0] mult_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: return b == 0 ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
            3'd4: return b == 0 ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // mult stand-in: Busy rises one cycle after start (or never, for zero latency), garbage on HI/LO while busy.
    // It deliberately ignores reset so a stale Busy drop after a mid-operation reset can be observed.
    logic        start_d = 1'b0;
    int          cnt = 0;
    int          lat_force = 0;
    int          lat_v;
    logic [31:0] res_hi = 32'd0;
    logic [31:0] res_lo = 32'd0;
    always @(posedge clk) begin
        start_d <= mul_start;
        if (mul_start) {res_hi, res_lo} <= mult_calc(mul_op, mul_A, mul_B);
        if (start_d) begin
            lat_v = lat_force > 0 ? lat_force : int'($urandom_range(0, 6));
            cnt <= lat_v;
            mul_busy <= lat_v != 0;
            mul_hi <= lat_v != 0 ? $urandom : res_hi;
            mul_lo <= lat_v != 0 ? $urandom : res_lo;
        end else if (mul_busy) begin
            mul_busy <= cnt > 1;
            mul_hi <= cnt > 1 ? $urandom : res_hi;
            mul_lo <= cnt > 1 ? $urandom : res_lo;
            cnt <= cnt - 1;
        end
    end

    // Behavioural model: an outstanding operation with an age in cycles since issue
    logic        known = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit          outs = 1'b0;
    int          age = 0;
    always @(posedge clk) begin
        if (!reset) begin
            known = 1'b1;
            m_hi = 32'd0;
            m_lo = 32'd0;
            outs = 1'b0;
        end else if (outs) begin
            if (age >= 2 && !mul_busy) begin
                m_hi = mul_hi;
                m_lo = mul_lo;
                outs = 1'b0;
            end
            age++;
        end else if (md_valid) begin
            if (md_op < 3'd4) begin
                outs = 1'b1;
                age = 1;
            end else if (md_op == 3'd6) m_hi = rs_val;
            else if (md_op == 3'd7) m_lo = rs_val;
        end
    end

    // Per-cycle comparison of every output against the model
    logic        go;
    logic [31:0] e_rd;
    always @(negedge clk) begin
        if (mul_start) n_starts++;
        if (known) begin
            go = reset && md_valid && !outs;
            e_rd = go && md_op == 3'd4 ? m_hi : go && md_op == 3'd5 ? m_lo : 32'd0;
            chk("stall", 32'(stall), 32'(reset && md_valid && outs));
            chk("mul_start", 32'(mul_start), 32'(go && md_op < 3'd4));
            chk("mul_op", 32'(mul_op), go && md_op < 3'd4 ? 32'(md_op) + 1 : 32'd0);
            chk("mul_A", mul_A, go && md_op < 3'd4 ? rs_val : 32'd0);
            chk("mul_B", mul_B, go && md_op < 3'd4 ? rt_val : 32'd0);
            chk("rd_data", rd_data, e_rd);
        end
    end

    // Present an instruction and hold it until it is no longer stalled; returns at the negedge of its retiring cycle
    task automatic instr(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        md_valid = 1'b1;
        md_op = o;
        rs_val = a;
        rt_val = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) return;
        end
        checks++;
        failures++;
        $display("FAIL instr_timeout op=%0d still stalled", o);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            md_valid = 1'b0;
        end
    endtask

    int s0;
    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        instr(3'd4, 0, 0);
        chk("reset_mfhi", rd_data, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        instr(3'd5, 0, 0);
        chk("reset_mflo", rd_data, 32'd0);
        instr(3'd0, 12, 16);
        chk("issue_start", 32'(mul_start), 32'd1);
        chk("issue_op", 32'(mul_op), 32'd1);
        instr(3'd5, 0, 0);
        chk("mult_lo", rd_data, 32'd192);
        instr(3'd4, 0, 0);
        chk("mult_hi", rd_data, 32'd0);
        instr(3'd1, 32'hffffbbbb, 32'h10);
        instr(3'd4, 0, 0);
        chk("multu_hi", rd_data, 32'h0000000f);
        instr(3'd5, 0, 0);
        chk("multu_lo", rd_data, 32'hfffbbbb0);
        s0 = n_starts;
        instr(3'd0, 32'hffffbbbb, 32'h10);
        instr(3'd0, 32'hffffbbbb, 32'h10);
        instr(3'd4, 0, 0);
        chk("mult_hi_s", rd_data, 32'hffffffff);
        instr(3'd5, 0, 0);
        chk("mult_lo_s", rd_data, 32'hfffbbbb0);
        chk("start_once", 32'(n_starts - s0), 32'd2);
        instr(3'd6, 32'hdeadbeef, 0);
        instr(3'd4, 0, 0);
        chk("mthi_mfhi", rd_data, 32'hdeadbeef);
        instr(3'd0, 3, 5);
        instr(3'd7, 32'h1234, 0);
        instr(3'd5, 0, 0);
        chk("mtlo_after_wait", rd_data, 32'h1234);
        instr(3'd4, 0, 0);
        chk("hi_from_mult", rd_data, 32'd0);
        lat_force = 8;
        instr(3'd0, 7, 9);
        idle(3);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        instr(3'd5, 0, 0);
        chk("midreset_lo", rd_data, 32'd0);
        chk("midreset_stall", 32'(stall), 32'd0);
        idle(12);
        lat_force = 0;
        instr(3'd5, 0, 0);
        chk("stale_lo", rd_data, 32'd0);
        instr(3'd4, 0, 0);
        chk("stale_hi", rd_data, 32'd0);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            reset = $urandom_range(0, 299) != 0;
            md_valid = 1'($urandom_range(0, 1));
            md_op = 3'($urandom);
            rs_val = $urandom;
            rt_val = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom;
        end
        reset = 1'b1;
        idle(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
